rr_mux_n: RTL and testbench
===========================

# rr_mux_n

Parametrised N-channel, W-bit registered multiplexer with valid/ready handshaking. Two modes: fixed select, which works like a plain select-driven mux, and round-robin arbitration among requesting channels. The winning word is captured into a one-entry output register, so the block can sit between pipeline stages of the MIPS datapath (writeback source merge, memory-port sharing) without lengthening the combinational path.

## Interface
Parameters:
- WIDTH, 32, data width per channel (1..64)
- CHANNELS, 4, number of input channels (2..8)
- SEL_W, 2, select/channel-index width; must satisfy 2^SEL_W >= CHANNELS

Ports:
- clk  input  1  rising-edge clock; the only clock
- rst_n  input  1  asynchronous, active-low reset
- mode  input  1  0 = fixed select, 1 = round-robin
- sel  input  SEL_W  channel index used in fixed mode
- in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  CHANNELS  per-channel request
- in_ready  output  CHANNELS  per-channel accept; at most one bit high
- out_data  output  WIDTH  registered selected word
- out_chan  output  SEL_W  index of the channel that supplied out_data
- out_valid  output  1  out_data is held and valid
- out_ready  input  1  downstream accept
- in_last  input  CHANNELS  end-of-packet flag per channel (only with RR_MUX_LOCK_EN)

## Operation
- Output register stage: `space = !out_valid || out_ready`.
- Grant g (combinational):
  - Fixed mode: g = sel. If sel >= CHANNELS, there is no grant.
  - RR mode: first channel with in_valid set, searching from ptr+1 upward modulo CHANNELS. If no channel is valid, there is no grant.
- Ready: in_ready[g] = space. All other in_ready bits = 0. In fixed mode, in_ready[sel] is high whenever space is true, independent of in_valid.
- Transfer (in_valid[g] && in_ready[g]) at a clock edge:
  - out_data <= in_data[g], out_chan <= g, out_valid <= 1.
  - In RR mode, ptr <= g.
- Without a transfer: if out_ready, then out_valid <= 0; out_data and out_chan hold their values.
- Fixed mode never updates ptr.
- Reset values: out_valid = 0, out_data = 0, out_chan = 0, ptr = CHANNELS-1 (so channel 0 has first priority), lock state cleared.
- Fairness: every continuously requesting channel is granted within CHANNELS transfers.

## Timing
- Latency: 1 cycle from accepted input to out_valid.
- Throughput: 1 word per cycle while out_ready is held high.
- in_ready depends combinationally on out_ready, mode, sel, in_valid and ptr. It has no combinational path from in_data.
- Backpressure: while out_valid = 1 and out_ready = 0, all in_ready = 0 and the outputs are stable.
- A change of mode or sel affects only the next arbitration. It never alters a held output word.
- If rst_n asserts mid-transfer, the outputs clear immediately (asynchronously). The first grant after release goes to channel 0 in RR mode.

## Configuration
- Macro: RR_MUX_LOCK_EN.
- Defined:
  - in_last exists.
  - In RR mode, a transfer with in_last[g] = 0 locks the grant to g. While locked, g is granted regardless of the other channels' requests.
  - The lock releases on a transfer with in_last[g] = 1.
  - Switching to fixed mode clears the lock.
- Undefined:
  - in_last is absent.
  - Every transfer is arbitrated independently.

## Test plan
- Reset, then rst_n high, mode = 1, in_valid = 4'b1111, out_ready = 1 → out_chan sequence 0,1,2,3,0 on successive cycles; out_data matches each channel's word one cycle after it is accepted.
- mode = 0, sel = 2, in_data ch2 = 32'hDEADBEEF, in_valid = 4'b0100 → in_ready = 4'b0100; next cycle out_data = 32'hDEADBEEF, out_chan = 2.
- Backpressure: out_valid = 1, out_ready = 0 for 3 cycles, all channels valid → in_ready = 0 and out_data stable for those 3 cycles; the next grant follows ptr+1.
- Only ch1 and ch3 valid, RR mode → grants alternate 1,3,1,3; ch0 and ch2 in_ready stay 0.
- rst_n low while out_valid = 1 → out_valid, out_data and out_chan read 0 before the next clock edge; after release the first grant is channel 0.
- RR_MUX_LOCK_EN defined: ch2 sends 3 beats with in_last = 0,0,1 while ch0 is requesting → out_chan = 2,2,2, then 0.

Source files
------------

// File: rtl/rr_mux_n.sv
// N-channel registered mux with valid/ready, fixed-select or round-robin grant.
// Optional packet locking in RR mode is enabled with `define RR_MUX_LOCK_EN (adds in_last).
module rr_mux_n #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
`ifdef RR_MUX_LOCK_EN
  ,
  input  logic [CHANNELS-1:0]       in_last
`endif
);

  logic [WIDTH-1:0] chan_data [CHANNELS];
  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_chan_q, out_chan_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] grant;
  logic             grant_vld;
  logic             space;
  logic             xfer;
  logic             lock_act;

  assign space = !out_valid_q || out_ready;
  assign xfer  = |(in_ready & in_valid);

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      assign chan_data[gi] = in_data[gi*WIDTH +: WIDTH];
      assign in_ready[gi]  = space && grant_vld && (grant == SEL_W'(gi));
    end
  endgenerate

  // RR search in two passes: channels above ptr first, then wrap to the low ones.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    if (!mode) begin
      grant     = sel;
      grant_vld = ({1'b0, sel} < (SEL_W+1)'(CHANNELS));
    end else if (lock_act) begin
      grant     = ptr_q;
      grant_vld = 1'b1;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (!grant_vld && in_valid[i] && (SEL_W'(i) > ptr_q)) begin
          grant_vld = 1'b1;
          grant     = SEL_W'(i);
        end
      end
      for (int i = 0; i < CHANNELS; i++) begin
        if (!grant_vld && in_valid[i]) begin
          grant_vld = 1'b1;
          grant     = SEL_W'(i);
        end
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant == SEL_W'(i)) sel_data = chan_data[i];
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_chan_d  = grant;
      if (mode) ptr_d = grant;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      ptr_q       <= SEL_W'(CHANNELS-1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      ptr_q       <= ptr_d;
    end
  end

`ifdef RR_MUX_LOCK_EN
  logic lock_q, lock_d;

  // The locked channel is always the last RR winner, which ptr already holds.
  assign lock_act = mode && lock_q;

  always_comb begin
    lock_d = lock_q;
    if (!mode) lock_d = 1'b0;
    else if (xfer) lock_d = !(|(in_ready & in_valid & in_last));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lock_q <= 1'b0;
    else        lock_q <= lock_d;
  end
`else
  assign lock_act = 1'b0;
`endif

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_mux_n.sv
// Self-checking bench for rr_mux_n: directed test-plan steps plus a randomized run
// compared against a cycle-level reference model of the arbitration rules.
module tb_rr_mux_n;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            mode;
  logic [SW-1:0]   sel;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [W-1:0]    out_data;
  logic [SW-1:0]   out_chan;
  logic            out_valid;
  logic            out_ready;
  logic [N-1:0]    in_last;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // reference model state
  int           m_ptr;
  bit           m_lock;
  bit           m_valid;
  logic [W-1:0] m_data;
  int           m_chan;

  rr_mux_n #(.WIDTH(W), .CHANNELS(N), .SEL_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef RR_MUX_LOCK_EN
    , .in_last(in_last)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = N-1; m_lock = 0; m_valid = 0; m_data = '0; m_chan = 0;
  endtask

  function automatic void model_grant(output bit gv, output int g);
    gv = 0; g = 0;
    if (!mode) begin
      gv = (int'(sel) < N); g = int'(sel);
`ifdef RR_MUX_LOCK_EN
    end else if (m_lock) begin
      gv = 1; g = m_ptr;
`endif
    end else begin
      for (int k = 1; k <= N; k++) begin
        if (!gv && in_valid[(m_ptr + k) % N]) begin
          gv = 1; g = (m_ptr + k) % N;
        end
      end
    end
  endfunction

  // One clock: check in_ready, advance the model, check registered outputs.
  task automatic cycle(input string tag);
    bit gv; int g; bit space; logic [N-1:0] exp_rdy;
    #1;
    model_grant(gv, g);
    space   = !m_valid || out_ready;
    exp_rdy = '0;
    if (gv && space) exp_rdy[g] = 1'b1;
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(exp_rdy));
    if (gv && space && in_valid[g]) begin
      m_valid = 1; m_data = in_data[g*W +: W]; m_chan = g;
      if (mode) begin
        m_ptr = g;
`ifdef RR_MUX_LOCK_EN
        m_lock = !in_last[g];
`endif
      end
    end else if (out_ready) begin
      m_valid = 0;
    end
    if (!mode) m_lock = 0;
    @(posedge clk); #1;
    cyc++;
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(m_valid));
    chk({tag, ".out_data"},  64'(out_data),  64'(m_data));
    chk({tag, ".out_chan"},  64'(out_chan),  64'(m_chan));
    $display("cyc=%0d %s mode=%b sel=%0d in_valid=%b in_ready=%b out_ready=%b -> out_valid=%b out_chan=%0d out_data=%h",
             cyc, tag, mode, sel, in_valid, exp_rdy, out_ready, out_valid, out_chan, out_data);
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++) in_data[i*W +: W] = $urandom;
  endtask

  initial begin
    int exp_rr[5];
    int exp_alt[4];
    logic [W-1:0] held;
    exp_rr  = '{0, 1, 2, 3, 0};
    exp_alt = '{3, 1, 3, 1};

    // reset
    rst_n = 1'b0; mode = 1'b1; sel = '0; in_valid = '0; in_last = '1;
    out_ready = 1'b1; in_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset.out_valid", 64'(out_valid), 64'(0));
    chk("reset.out_data",  64'(out_data),  64'(0));
    chk("reset.out_chan",  64'(out_chan),  64'(0));
    rst_n = 1'b1;

    // RR with all channels requesting
    in_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      rand_data();
      cycle("rr_all");
      chk("rr_all.seq", 64'(out_chan), 64'(exp_rr[i]));
    end

    // fixed select on channel 2
    mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; rand_data();
    in_data[2*W +: W] = 32'hDEADBEEF;
    #1;
    chk("fixed.in_ready_const", 64'(in_ready), 64'(4'b0100));
    cycle("fixed");
    chk("fixed.data_const", 64'(out_data), 64'(32'hDEADBEEF));
    chk("fixed.chan_const", 64'(out_chan), 64'(2));

    // backpressure for 3 cycles, then release
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b0;
    held = out_data;
    for (int i = 0; i < 3; i++) begin
      rand_data();
      cycle("bp");
      chk("bp.hold", 64'(out_data), 64'(held));
    end
    out_ready = 1'b1; rand_data();
    cycle("bp_release");
    chk("bp_release.chan", 64'(out_chan), 64'(1));

    // only ch1 and ch3 requesting
    in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      rand_data();
      cycle("alt");
      chk("alt.seq", 64'(out_chan), 64'(exp_alt[i]));
    end

    // async reset while output is valid
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst.out_valid", 64'(out_valid), 64'(0));
    chk("async_rst.out_data",  64'(out_data),  64'(0));
    chk("async_rst.out_chan",  64'(out_chan),  64'(0));
    rst_n = 1'b1;
    in_valid = 4'b1111; rand_data();
    cycle("post_rst");
    chk("post_rst.chan", 64'(out_chan), 64'(0));

`ifdef RR_MUX_LOCK_EN
    // packet lock: ch2 sends 3 beats while ch0 keeps requesting
    in_valid = 4'b0010; in_last = 4'b1111; rand_data();
    cycle("lock_pre");
    in_valid = 4'b0101; in_last = 4'b0000;
    rand_data(); cycle("lock_b0"); chk("lock_b0.chan", 64'(out_chan), 64'(2));
    rand_data(); cycle("lock_b1"); chk("lock_b1.chan", 64'(out_chan), 64'(2));
    in_last = 4'b0100;
    rand_data(); cycle("lock_b2"); chk("lock_b2.chan", 64'(out_chan), 64'(2));
    in_last = 4'b1111;
    rand_data(); cycle("lock_after"); chk("lock_after.chan", 64'(out_chan), 64'(0));
`endif

    // randomized run against the model
    for (int i = 0; i < 400; i++) begin
      mode      = ($urandom_range(0, 3) != 0);
      sel       = SW'($urandom_range(0, N-1));
      in_valid  = N'($urandom);
      in_last   = N'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      rand_data();
      cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
